// File: rtl/key_event_queue_pkg.sv
// Shared event-byte layout and key/polarity source encoding for the key event queue.
package key_event_queue_pkg;

    localparam int EV_POL_BIT = 7;
    localparam int EV_KEY_LSB = 0;
    localparam int EV_KEY_W   = 3;
    localparam int EV_W       = 8;
    localparam int SRC_W      = EV_KEY_W + 1;

    typedef enum logic {
        POL_FALL = 1'b0,
        POL_RISE = 1'b1
    } pol_e;

    // Source index s = 2*key + pol, so the LSB is the polarity.
    function automatic logic [SRC_W-1:0] src_index(input logic [EV_KEY_W-1:0] key, input pol_e pol);
        return {key, pol};
    endfunction

    function automatic logic [EV_W-1:0] make_event(input logic [SRC_W-1:0] src);
        logic [EV_W-1:0] ev;
        ev = '0;
        ev[EV_POL_BIT] = src[0];
        ev[EV_KEY_LSB +: EV_KEY_W] = src[SRC_W-1:1];
        return ev;
    endfunction

endpackage

// File: rtl/key_event_queue_sync_fifo.sv
// First-word fall-through FIFO with occupancy count; head reads as zero when empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/key_event_queue.sv
// Collects debounced key edge pulses into pending bits and feeds them round-robin into an event FIFO.
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter int NKEYS = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NKEYS-1:0]         key_rise,
    input  logic [NKEYS-1:0]         key_fall,
    input  logic                     rd_en,
    output logic [EV_W-1:0]          rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int NSRC = 2 * NKEYS;
    localparam int SW1  = SRC_W + 1;

    logic [NSRC-1:0]  pending_q, pending_d;
    logic [NSRC-1:0]  set_vec, grant_vec;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             overflow_q, overflow_d;
    logic             grant_valid;
    logic [SRC_W-1:0] grant_src;
    logic [SRC_W-1:0] cand;
    logic [SW1-1:0]   sum;
    logic             lost;
    logic             fifo_full;

    // Grant only when the FIFO had room at cycle start; a same-cycle pop does not open a slot.
    always_comb begin
        set_vec     = '0;
        grant_valid = 1'b0;
        grant_src   = '0;
        grant_vec   = '0;
        cand        = '0;
        sum         = '0;
        for (int k = 0; k < NKEYS; k++) begin
            set_vec[src_index(EV_KEY_W'(k), POL_RISE)] = key_rise[k];
            set_vec[src_index(EV_KEY_W'(k), POL_FALL)] = key_fall[k];
        end
        if (!fifo_full) begin
            for (int i = 0; i < NSRC; i++) begin
                sum = {1'b0, rr_ptr_q} + SW1'(i);
                if (sum >= SW1'(NSRC)) sum = sum - SW1'(NSRC);
                cand = sum[SRC_W-1:0];
                if (!grant_valid && pending_q[cand]) begin
                    grant_valid = 1'b1;
                    grant_src   = cand;
                end
            end
        end
        if (grant_valid) grant_vec[grant_src] = 1'b1;

        // A pulse on the source being granted this cycle is a fresh event, not a loss.
        lost       = |(set_vec & pending_q & ~grant_vec);
        pending_d  = (pending_q & ~grant_vec) | set_vec;
        overflow_d = lost | (overflow_q & ~clr_ovf);
        rr_ptr_d   = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_src == SRC_W'(NSRC - 1)) ? '0 : grant_src + SRC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (grant_valid),
        .wr_data_i (make_event(grant_src)),
        .pop_i     (rd_en),
        .rd_data_o (rd_data),
        .empty_o   (empty),
        .full_o    (fifo_full),
        .count_o   (count)
    );

    assign full     = fifo_full;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed self-checking bench for key_event_queue with NKEYS = 8, DEPTH = 4.
module tb_key_event_queue;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_rise;
    logic [7:0] key_fall;
    logic       rd_en;
    logic       clr_ovf;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;

    int nCompared;
    int nMismatched;

    key_event_queue #(
        .NKEYS (8),
        .DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_rise (key_rise),
        .key_fall (key_fall),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_rise = '0; key_fall = '0; rd_en = 1'b0; clr_ovf = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        nCompared++; if (empty !== 1'b1)    begin nMismatched++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        nCompared++; if (full !== 1'b0)     begin nMismatched++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
        nCompared++; if (count !== 3'd0)    begin nMismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        nCompared++; if (rd_data !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data); end
        nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_fall();
        do_reset();
        key_fall = 8'h04;
        tick();
        key_fall = '0;
        nCompared++; if (empty !== 1'b1)    begin nMismatched++; $display("[TB] FAIL fall_latency_empty: got %b expected 1", empty); end
        tick();
        nCompared++; if (rd_data !== 8'h02) begin nMismatched++; $display("[TB] FAIL fall_rd_data: got %h expected 02", rd_data); end
        nCompared++; if (empty !== 1'b0)    begin nMismatched++; $display("[TB] FAIL fall_empty: got %b expected 0", empty); end
        nCompared++; if (count !== 3'd1)    begin nMismatched++; $display("[TB] FAIL fall_count: got %0d expected 1", count); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        nCompared++; if (empty !== 1'b1)    begin nMismatched++; $display("[TB] FAIL fall_pop_empty: got %b expected 1", empty); end
        nCompared++; if (rd_data !== 8'h00) begin nMismatched++; $display("[TB] FAIL fall_pop_rd_data: got %h expected 00", rd_data); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        key_rise = 8'h21;
        tick();
        key_rise = '0;
        tick();
        nCompared++; if (rd_data !== 8'h80) begin nMismatched++; $display("[TB] FAIL same_first: got %h expected 80", rd_data); end
        nCompared++; if (count !== 3'd1)    begin nMismatched++; $display("[TB] FAIL same_count1: got %0d expected 1", count); end
        tick();
        nCompared++; if (count !== 3'd2)    begin nMismatched++; $display("[TB] FAIL same_count2: got %0d expected 2", count); end
        nCompared++; if (rd_data !== 8'h80) begin nMismatched++; $display("[TB] FAIL same_head: got %h expected 80", rd_data); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        nCompared++; if (rd_data !== 8'h85) begin nMismatched++; $display("[TB] FAIL same_second: got %h expected 85", rd_data); end
        nCompared++; if (count !== 3'd1)    begin nMismatched++; $display("[TB] FAIL same_count3: got %0d expected 1", count); end
    endtask

    task automatic test_regrant();
        do_reset();
        key_rise = 8'h02;
        tick();
        tick();
        key_rise = '0;
        nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL regrant_ovf1: got %b expected 0", overflow); end
        nCompared++; if (count !== 3'd1)    begin nMismatched++; $display("[TB] FAIL regrant_count1: got %0d expected 1", count); end
        tick();
        nCompared++; if (count !== 3'd2)    begin nMismatched++; $display("[TB] FAIL regrant_count2: got %0d expected 2", count); end
        nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL regrant_ovf2: got %b expected 0", overflow); end
        nCompared++; if (rd_data !== 8'h81) begin nMismatched++; $display("[TB] FAIL regrant_head: got %h expected 81", rd_data); end
    endtask

    task automatic test_fill();
        logic [7:0] expEv [6] = '{8'h80, 8'h81, 8'h82, 8'h03, 8'h04, 8'h05};
        do_reset();
        key_rise = 8'h07;
        key_fall = 8'h38;
        tick();
        key_rise = '0;
        key_fall = '0;
        repeat (6) tick();
        nCompared++; if (full !== 1'b1)     begin nMismatched++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
        nCompared++; if (count !== 3'd4)    begin nMismatched++; $display("[TB] FAIL fill_count: got %0d expected 4", count); end
        nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL fill_ovf: got %b expected 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            nCompared++; if (rd_data !== expEv[i]) begin nMismatched++; $display("[TB] FAIL fill_pop%0d: got %h expected %h", i, rd_data, expEv[i]); end
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        nCompared++; if (count !== 3'd2)    begin nMismatched++; $display("[TB] FAIL fill_remaining: got %0d expected 2", count); end
        for (int i = 4; i < 6; i++) begin
            nCompared++; if (rd_data !== expEv[i]) begin nMismatched++; $display("[TB] FAIL fill_pop%0d: got %h expected %h", i, rd_data, expEv[i]); end
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        nCompared++; if (empty !== 1'b1)    begin nMismatched++; $display("[TB] FAIL fill_drained: got %b expected 1", empty); end
    endtask

    task automatic test_overflow();
        logic [7:0] expEv [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h83};
        do_reset();
        key_fall = 8'h0F;
        tick();
        key_fall = '0;
        repeat (5) tick();
        nCompared++; if (full !== 1'b1)     begin nMismatched++; $display("[TB] FAIL ovf_full: got %b expected 1", full); end
        key_rise = 8'h08;
        tick();
        nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_first_pulse: got %b expected 0", overflow); end
        tick();
        key_rise = '0;
        nCompared++; if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
        key_rise = 8'h08;
        clr_ovf  = 1'b1;
        tick();
        key_rise = '0;
        clr_ovf  = 1'b0;
        nCompared++; if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_set_wins: got %b expected 1", overflow); end
        for (int i = 0; i < 5; i++) begin
            nCompared++; if (rd_data !== expEv[i]) begin nMismatched++; $display("[TB] FAIL ovf_pop%0d: got %h expected %h", i, rd_data, expEv[i]); end
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        tick();
        tick();
        nCompared++; if (empty !== 1'b1)    begin nMismatched++; $display("[TB] FAIL ovf_single_83: got empty=%b expected 1", empty); end
        nCompared++; if (count !== 3'd0)    begin nMismatched++; $display("[TB] FAIL ovf_end_count: got %0d expected 0", count); end
        nCompared++; if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_empty_read_and_reset();
        do_reset();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        nCompared++; if (count !== 3'd0)    begin nMismatched++; $display("[TB] FAIL empty_read_count: got %0d expected 0", count); end
        nCompared++; if (empty !== 1'b1)    begin nMismatched++; $display("[TB] FAIL empty_read_empty: got %b expected 1", empty); end
        key_fall = 8'h07;
        tick();
        key_fall = '0;
        repeat (4) tick();
        nCompared++; if (count !== 3'd3)    begin nMismatched++; $display("[TB] FAIL midreset_pre_count: got %0d expected 3", count); end
        nCompared++; if (rd_data !== 8'h00) begin nMismatched++; $display("[TB] FAIL midreset_head: got %h expected 00", rd_data); end
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++; if (empty !== 1'b1)    begin nMismatched++; $display("[TB] FAIL midreset_empty: got %b expected 1", empty); end
        nCompared++; if (count !== 3'd0)    begin nMismatched++; $display("[TB] FAIL midreset_count: got %0d expected 0", count); end
        nCompared++; if (rd_data !== 8'h00) begin nMismatched++; $display("[TB] FAIL midreset_rd_data: got %h expected 00", rd_data); end
        tick();
        rst_n = 1'b1;
        tick();
        nCompared++; if (empty !== 1'b1)    begin nMismatched++; $display("[TB] FAIL postreset_empty: got %b expected 1", empty); end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst_n    = 1'b0;
        key_rise = '0;
        key_fall = '0;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;
        test_reset();
        test_single_fall();
        test_same_cycle();
        test_regrant();
        test_fill();
        test_overflow();
        test_empty_read_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 SHALL have parameter NKEYS, default 8, number of debounced key channels (1..8).
REQ-002 SHALL have parameter DEPTH, default 4, event FIFO depth (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key_rise  input  NKEYS  one-cycle rising-edge pulses from per-key debouncers.
REQ-006 SHALL have port key_fall  input  NKEYS  one-cycle falling-edge pulses from per-key debouncers.
REQ-007 SHALL have port rd_en  input  1  CPU pop strobe, one cycle per event consumed.
REQ-008 SHALL have port rd_data  output  8  head event: bit7 = 1 rising / 0 falling, bits6:3 = 0, bits2:0 = key index.
REQ-009 SHALL have port empty  output  1  FIFO holds no event.
REQ-010 SHALL have port full  output  1  FIFO holds DEPTH events.
REQ-011 SHALL have port count  output  clog2(DEPTH)+1  events held.
REQ-012 SHALL have port overflow  output  1  sticky flag: an event was lost.
REQ-013 SHALL have port clr_ovf  input  1  one-cycle clear of overflow.

Function
REQ-014 SHALL hold 2*NKEYS pending bits, source s = 2*k + pol (pol 1 = rise), set by the matching input pulse.
REQ-015 SHALL, each cycle FIFO is not full at cycle start, grant one pending source round-robin, push its event, and clear its pending bit.
REQ-016 SHALL start the round-robin search at (last granted s + 1) mod 2*NKEYS; pointer 0 after reset.
REQ-017 SHALL not push while full at cycle start, even if rd_en pops in the same cycle; pending bits keep waiting.
REQ-018 SHALL, when a pulse arrives for a source already pending and not granted that cycle, keep one pending bit and set overflow.
REQ-019 SHALL, when a pulse arrives for a source granted in the same cycle, leave the bit set (new event pending), no overflow.
REQ-020 SHALL present the head event on rd_data combinationally whenever !empty (first-word fall-through); rd_data = 0 when empty.
REQ-021 SHALL ignore rd_en while empty (no pointer or count change).
REQ-022 SHALL support push and pop in the same cycle when neither full nor empty; count unchanged.
REQ-023 SHALL wrap read/write pointers modulo DEPTH.
REQ-024 SHALL give latency: pulse at edge N -> pending after N -> in FIFO after N+1 -> on rd_data before edge N+2, if uncontended.
REQ-025 SHALL let overflow set win over clr_ovf in the same cycle.
REQ-026 SHALL ignore key_rise/key_fall bits at index >= NKEYS.

Reset
REQ-027 SHALL, on rst_n low, immediately clear pending bits, pointers, count, overflow, round-robin pointer; empty = 1, full = 0, rd_data = 0.
REQ-028 SHALL discard all queued and pending events on reset mid-operation; pulses while rst_n low are lost.

Structure
REQ-029 SHALL place event-byte bit positions (EV_POL_BIT = 7, EV_KEY_LSB = 0, EV_KEY_W = 3) and the source-index encoding in a shared package.
REQ-030 SHALL implement storage as sub-module sync_fifo (FWFT, DEPTH x 8, count/full/empty); arbitration and pending logic stay in key_event_queue.

Verification
REQ-031 SHALL cover: key_fall[2] pulse, FIFO empty -> rd_data = 0x02 and empty = 0 two edges later, count = 1.
REQ-032 SHALL cover: key_rise[0] and key_rise[5] same cycle -> events 0x80 then 0x85 on consecutive cycles.
REQ-033 SHALL cover: 6 distinct pulses, DEPTH = 4, no reads -> full = 1, count = 4, overflow = 0; 4 pops -> remaining 2 events drain in order.
REQ-034 SHALL cover: key_rise[3] twice while FIFO full -> overflow = 1, only one 0x83 delivered; clr_ovf -> overflow = 0.
REQ-035 SHALL cover: rd_en while empty -> count stays 0; rst_n low with count = 3 -> empty = 1, count = 0 without a clock edge.
